// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle main control unit: opcodes,
// function codes, FSM state encoding, ALU operation codes and mux selects.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_OR  = 6'b100101;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_IEXEC  = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    // Operation class handed to the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_OR    = 2'b11
    } aluop_t;

    // Every datapath control of the unit, bundled so reset can clear them at once
    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_op;
        logic [2:0] alu_control;
        logic [1:0] pc_src;
        logic       pc_en;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU decoder: maps the operation class and Funct field to the
// ALU's 3-bit control code and flags whether Funct is a supported R-type op.
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  aluop_t      alu_op,
    input  logic [5:0]  funct,
    output logic [2:0]  alu_control,
    output logic        funct_valid
);

    logic [2:0] funct_ctl_s;

    // Funct decode, independent of class so DECODE can check legality
    always_comb begin
        funct_ctl_s = ALU_ADD;
        funct_valid = 1'b0;
        case (funct)
            FN_ADD: begin funct_ctl_s = ALU_ADD; funct_valid = 1'b1; end
            FN_SUB: begin funct_ctl_s = ALU_SUB; funct_valid = 1'b1; end
            FN_OR:  begin funct_ctl_s = ALU_OR;  funct_valid = 1'b1; end
            default: begin funct_ctl_s = ALU_ADD; funct_valid = 1'b0; end
        endcase
    end

    // Select between fixed operations and the Funct-derived one
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD:   alu_control = ALU_ADD;
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_OR:    alu_control = ALU_OR;
            ALUOP_FUNCT: alu_control = funct_ctl_s;
            default:     alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle main control FSM. Sequences FETCH..WRITEBACK, decodes Op/Funct,
// resolves beq with the ALU Zero flag and suppresses writeback on overflow.
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter logic TRAP_ON_OVF = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  Op,
    input  logic [5:0]  Funct,
    input  logic        Zero,
    input  logic        Overflow,
    output logic        IorD,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        ExtOp,
    output logic [2:0]  ALUControl,
    output logic [1:0]  PCSrc,
    output logic        PCEn,
    output logic        Illegal
);

    state_t     state_q, state_d;
    logic       ovf_q, ovf_d;
    aluop_t     alu_op_s;
    logic [2:0] alu_ctl_s;
    logic       funct_valid_s;
    logic       op_legal_s;
    ctrl_t      ctrl_s;
    ctrl_t      ctrl_out_s;

    mc_alu_decoder u_alu_dec (
        .alu_op      (alu_op_s),
        .funct       (Funct),
        .alu_control (alu_ctl_s),
        .funct_valid (funct_valid_s)
    );

    // ALU operation class for the current state
    always_comb begin
        alu_op_s = ALUOP_ADD;
        case (state_q)
            S_EXEC:   alu_op_s = ALUOP_FUNCT;
            S_IEXEC:  alu_op_s = (Op == OP_ORI) ? ALUOP_OR : ALUOP_ADD;
            S_BRANCH: alu_op_s = ALUOP_SUB;
            default:  alu_op_s = ALUOP_ADD;
        endcase
    end

    // Instruction legality: supported opcode, and supported Funct for R-type
    always_comb begin
        op_legal_s = 1'b0;
        case (Op)
            OP_RTYPE: op_legal_s = funct_valid_s;
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI, OP_J: op_legal_s = 1'b1;
            default:  op_legal_s = 1'b0;
        endcase
    end

    // State register and captured overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic; unknown encodings fall back to FETCH
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (!op_legal_s) begin
                    state_d = S_FETCH;
                end else begin
                    case (Op)
                        OP_LW, OP_SW:    state_d = S_MEMADR;
                        OP_RTYPE:        state_d = S_EXEC;
                        OP_BEQ:          state_d = S_BRANCH;
                        OP_ADDI, OP_ORI: state_d = S_IEXEC;
                        OP_J:            state_d = S_JUMP;
                        default:         state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_RWB;
            S_IEXEC:  state_d = S_IWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Overflow capture: only add/sub/addi can overflow; cleared on every fetch
    always_comb begin
        ovf_d = ovf_q;
        case (state_q)
            S_FETCH: ovf_d = 1'b0;
            S_EXEC:  ovf_d = Overflow & (alu_ctl_s != ALU_OR);
            S_IEXEC: ovf_d = Overflow & (Op == OP_ADDI);
            default: ovf_d = ovf_q;
        endcase
    end

    // Moore outputs per state, plus the Zero-qualified PC enable in BRANCH
    always_comb begin
        ctrl_s = '0;
        case (state_q)
            S_FETCH: begin
                ctrl_s.ir_write  = 1'b1;
                ctrl_s.pc_en     = 1'b1;
                ctrl_s.alu_src_b = SRCB_FOUR;
            end
            S_DECODE: begin
                ctrl_s.alu_src_b = SRCB_BRANCH;
                ctrl_s.illegal   = !op_legal_s;
            end
            S_MEMADR: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: ctrl_s.iord = 1'b1;
            S_MEMWB: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_s.iord      = 1'b1;
                ctrl_s.mem_write = 1'b1;
            end
            S_EXEC: begin
                ctrl_s.alu_src_a   = 1'b1;
                ctrl_s.alu_control = alu_ctl_s;
            end
            S_RWB: begin
                ctrl_s.reg_dst   = 1'b1;
                ctrl_s.reg_write = !(TRAP_ON_OVF && ovf_q);
            end
            S_IEXEC: begin
                ctrl_s.alu_src_a   = 1'b1;
                ctrl_s.alu_src_b   = SRCB_IMM;
                ctrl_s.alu_control = alu_ctl_s;
                ctrl_s.ext_op      = (Op == OP_ORI);
            end
            S_IWB: ctrl_s.reg_write = !(TRAP_ON_OVF && ovf_q);
            S_BRANCH: begin
                ctrl_s.alu_src_a   = 1'b1;
                ctrl_s.alu_control = alu_ctl_s;
                ctrl_s.pc_src      = PCSRC_ALUOUT;
                ctrl_s.pc_en       = Zero;
            end
            S_JUMP: begin
                ctrl_s.pc_src = PCSRC_JUMP;
                ctrl_s.pc_en  = 1'b1;
            end
            default: ctrl_s = '0;
        endcase
    end

    // Reset holds every control low, including the FETCH strobes
    always_comb begin
        if (rst) begin
            ctrl_out_s = '0;
        end else begin
            ctrl_out_s = ctrl_s;
        end
    end

    assign IorD       = ctrl_out_s.iord;
    assign MemWrite   = ctrl_out_s.mem_write;
    assign IRWrite    = ctrl_out_s.ir_write;
    assign RegDst     = ctrl_out_s.reg_dst;
    assign MemtoReg   = ctrl_out_s.mem_to_reg;
    assign RegWrite   = ctrl_out_s.reg_write;
    assign ALUSrcA    = ctrl_out_s.alu_src_a;
    assign ALUSrcB    = ctrl_out_s.alu_src_b;
    assign ExtOp      = ctrl_out_s.ext_op;
    assign ALUControl = ctrl_out_s.alu_control;
    assign PCSrc      = ctrl_out_s.pc_src;
    assign PCEn       = ctrl_out_s.pc_en;
    assign Illegal    = ctrl_out_s.illegal;

endmodule

// File: tb/tb_mc_control_unit.sv
// Testbench for mc_control_unit: directed and random instruction streams,
// each expanded into the per-cycle control vectors the instruction should produce.
module tb_mc_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op, Funct;
    logic       Zero, Overflow;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic       ExtOp, PCEn, Illegal;
    logic [2:0] ALUControl;

    int n_err = 0;
    int n_chk = 0;

    logic [16:0] exp_q[$];
    logic [1:0]  in_q[$];
    string       cur_name;

    mc_control_unit dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .Overflow(Overflow),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ExtOp(ExtOp), .ALUControl(ALUControl), .PCSrc(PCSrc), .PCEn(PCEn), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    wire [16:0] obs = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                       ALUSrcB, ExtOp, ALUControl, PCSrc, PCEn, Illegal};

    function automatic logic [16:0] v(input logic iord, input logic memw, input logic irw,
                                      input logic regdst, input logic m2r, input logic regw,
                                      input logic srca, input logic [1:0] srcb, input logic ext,
                                      input logic [2:0] aluc, input logic [1:0] pcs,
                                      input logic pcen, input logic ill);
        return {iord, memw, irw, regdst, m2r, regw, srca, srcb, ext, aluc, pcs, pcen, ill};
    endfunction

    function automatic logic [1:0] rnd2();
        return 2'($urandom_range(0, 3));
    endfunction

    task automatic chk(input string tag, input logic [16:0] o, input logic [16:0] e);
        n_chk++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=%05h expected=%05h", tag, o, e);
        end
    endtask

    // Expand one instruction into its expected cycle-by-cycle controls.
    // z is the Zero seen in BRANCH, o the Overflow seen in the execute cycle.
    task automatic build(input string name, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input logic o);
        logic       legal;
        logic [2:0] rop;
        logic       arith;
        cur_name = name;
        legal = 1'b1;
        rop   = 3'b000;
        arith = 1'b1;
        if (op == 6'b000000) begin
            if (fn == 6'b100000)      rop = 3'b000;
            else if (fn == 6'b100010) rop = 3'b001;
            else if (fn == 6'b100101) begin rop = 3'b010; arith = 1'b0; end
            else legal = 1'b0;
        end else if (!(op inside {6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b001101, 6'b000010})) begin
            legal = 1'b0;
        end
        Op = op;
        Funct = fn;
        exp_q.push_back(v(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,3'b000,2'b00,1'b1,1'b0));
        in_q.push_back(rnd2());
        exp_q.push_back(v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,1'b0,3'b000,2'b00,1'b0,!legal));
        in_q.push_back(rnd2());
        if (legal) begin
            case (op)
                6'b100011, 6'b101011: begin
                    exp_q.push_back(v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,3'b000,2'b00,1'b0,1'b0));
                    in_q.push_back(rnd2());
                    if (op == 6'b100011) begin
                        exp_q.push_back(v(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,3'b000,2'b00,1'b0,1'b0));
                        in_q.push_back(rnd2());
                        exp_q.push_back(v(1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,1'b0,3'b000,2'b00,1'b0,1'b0));
                        in_q.push_back(rnd2());
                    end else begin
                        exp_q.push_back(v(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,3'b000,2'b00,1'b0,1'b0));
                        in_q.push_back(rnd2());
                    end
                end
                6'b000000: begin
                    exp_q.push_back(v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,rop,2'b00,1'b0,1'b0));
                    in_q.push_back({1'($urandom_range(0, 1)), o});
                    exp_q.push_back(v(1'b0,1'b0,1'b0,1'b1,1'b0,!(o && arith),1'b0,2'b00,1'b0,3'b000,2'b00,1'b0,1'b0));
                    in_q.push_back(rnd2());
                end
                6'b001000, 6'b001101: begin
                    arith = (op == 6'b001000);
                    exp_q.push_back(v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,!arith,
                                      arith ? 3'b000 : 3'b010,2'b00,1'b0,1'b0));
                    in_q.push_back({1'($urandom_range(0, 1)), o});
                    exp_q.push_back(v(1'b0,1'b0,1'b0,1'b0,1'b0,!(o && arith),1'b0,2'b00,1'b0,3'b000,2'b00,1'b0,1'b0));
                    in_q.push_back(rnd2());
                end
                6'b000100: begin
                    exp_q.push_back(v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,3'b001,2'b01,z,1'b0));
                    in_q.push_back({z, 1'($urandom_range(0, 1))});
                end
                default: begin
                    exp_q.push_back(v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,3'b000,2'b10,1'b1,1'b0));
                    in_q.push_back(rnd2());
                end
            endcase
        end
    endtask

    // Play the first upto expected cycles (all if negative), then drop the rest
    task automatic run_q(input int upto);
        int n;
        n = (upto < 0 || upto > exp_q.size()) ? exp_q.size() : upto;
        for (int i = 0; i < n; i++) begin
            Zero = in_q[i][1];
            Overflow = in_q[i][0];
            #1;
            chk($sformatf("%s_c%0d", cur_name, i), obs, exp_q[i]);
            @(posedge clk);
            #1;
        end
        exp_q.delete();
        in_q.delete();
    endtask

    initial begin
        logic [5:0] ops[11];
        logic [5:0] fns[11];
        int k;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b000000, 6'b001000,
                6'b001101, 6'b000100, 6'b000010, 6'b111111, 6'b000000};
        fns = '{6'b000000, 6'b000000, 6'b100000, 6'b100010, 6'b100101, 6'b000000,
                6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b101010};

        rst = 1'b1; Op = 6'b100011; Funct = 6'b000000; Zero = 1'b1; Overflow = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", obs, 17'h0);
        rst = 1'b0;

        build("lw", 6'b100011, 6'b000000, 1'b0, 1'b0);           run_q(-1);
        build("add_ovf", 6'b000000, 6'b100000, 1'b0, 1'b1);      run_q(-1);
        build("add_noovf", 6'b000000, 6'b100000, 1'b0, 1'b0);    run_q(-1);
        build("beq_taken", 6'b000100, 6'b000000, 1'b1, 1'b0);    run_q(-1);
        build("beq_nottaken", 6'b000100, 6'b000000, 1'b0, 1'b1); run_q(-1);
        build("ori_ovf", 6'b001101, 6'b000000, 1'b0, 1'b1);      run_q(-1);
        build("ill_op", 6'b111111, 6'b000000, 1'b0, 1'b0);       run_q(-1);
        build("ill_funct", 6'b000000, 6'b101010, 1'b0, 1'b0);    run_q(-1);
        build("sw", 6'b101011, 6'b000000, 1'b0, 1'b0);           run_q(-1);
        build("j", 6'b000010, 6'b000000, 1'b0, 1'b0);            run_q(-1);
        build("addi_ovf", 6'b001000, 6'b000000, 1'b0, 1'b1);     run_q(-1);
        build("sub_ovf", 6'b000000, 6'b100010, 1'b0, 1'b1);      run_q(-1);
        build("or_ovf", 6'b000000, 6'b100101, 1'b0, 1'b1);       run_q(-1);

        // Reset arriving in the writeback cycle of a load
        build("lw_rst", 6'b100011, 6'b000000, 1'b0, 1'b0);
        run_q(4);
        Zero = 1'b0; Overflow = 1'b0;
        #1;
        chk("lw_rst_memwb", obs, v(1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,1'b0,3'b000,2'b00,1'b0,1'b0));
        rst = 1'b1;
        #1;
        chk("rst_async_zero", obs, 17'h0);
        @(posedge clk);
        #1;
        chk("rst_held_zero", obs, 17'h0);
        rst = 1'b0;
        #1;
        chk("rst_release_fetch", obs, v(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,3'b000,2'b00,1'b1,1'b0));

        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 10);
            build($sformatf("rnd%0d", i), ops[k], fns[k], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            run_q(-1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
